// File: rtl/pbit_sched_pkg.sv
// Shared constants and state type for the p-bit group sequencer.
// The group-enable LUT uses the same NUM_GROUPS / GROUP_W.
package pbit_sched_pkg;

    localparam int NUM_GROUPS = 5;
    localparam int GROUP_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/pbit_group_scheduler.sv
// Steps the colour-group select through dwell-timed sweeps,
// counts sweeps, strobes sample capture and flags completion.
module pbit_group_scheduler #(
    parameter int NUM_GROUPS = pbit_sched_pkg::NUM_GROUPS,
    parameter int GROUP_W    = pbit_sched_pkg::GROUP_W,
    parameter int DWELL_W    = 8,
    parameter int SWEEP_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [GROUP_W-1:0] group_EN,
    output logic               group_valid,
    output logic               busy,
    output logic               sample_strobe,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               done
);

    import pbit_sched_pkg::*;

    localparam logic [GROUP_W-1:0] LAST_GRP = GROUP_W'(NUM_GROUPS - 1);

    sched_state_t       state_q, state_d;
    logic [GROUP_W-1:0] grp_q, grp_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dlen_q, dlen_d;
    logic [SWEEP_W-1:0] nsw_q, nsw_d;
    logic [SWEEP_W-1:0] cnt_q, cnt_d;
    logic [SWEEP_W-1:0] cnt_inc;
    logic [DWELL_W-1:0] dlen_start;
    logic               strobe_d;
    logic               done_d;

    logic [GROUP_W-1:0] group_en_d;
    logic               valid_d;
    logic               busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            dwell_q <= '0;
            dlen_q  <= '0;
            nsw_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            dwell_q <= dwell_d;
            dlen_q  <= dlen_d;
            nsw_q   <= nsw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dlen_start = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        dwell_d  = dwell_q;
        dlen_d   = dlen_q;
        nsw_d    = nsw_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    dlen_d  = dlen_start;
                    nsw_d   = num_sweeps;
                    cnt_d   = '0;
                    dwell_d = dlen_start - 1'b1;
                    grp_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    grp_d   = '0;
                    state_d = IDLE;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - 1'b1;
                end else if (grp_q != LAST_GRP) begin
                    grp_d   = grp_q + 1'b1;
                    dwell_d = dlen_q - 1'b1;
                end else begin
                    // sweep boundary: count it, then finish or wrap
                    cnt_d    = cnt_inc;
                    strobe_d = 1'b1;
                    grp_d    = '0;
                    dwell_d  = dlen_q - 1'b1;
                    if (nsw_q != '0 && cnt_inc == nsw_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grp_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_d    = (state_d == RUN);
        busy_d     = (state_d == RUN);
        group_en_d = (state_d == RUN) ? grp_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            group_EN      <= '0;
            group_valid   <= 1'b0;
            busy          <= 1'b0;
            sample_strobe <= 1'b0;
            sweep_cnt     <= '0;
            done          <= 1'b0;
        end else begin
            group_EN      <= group_en_d;
            group_valid   <= valid_d;
            busy          <= busy_d;
            sample_strobe <= strobe_d;
            sweep_cnt     <= cnt_d;
            done          <= done_d;
        end
    end

endmodule
